// File: rtl/dp_operand_loader_if.sv
// rtl/dp_operand_loader_if.sv - operand, engine and result signals of the dot-product operand loader
//
// Groups every non-clock/reset signal of dp_operand_loader.
//   in_valid/in_ready/in_pixel/in_weight/in_last : serial operand pair stream
//   dp_pixels/dp_weights/dp_rst/dp_value          : dot-product engine connection
//   res_valid/res_ready/res_data                  : single-beat result stream
// Modports:
//   slave  : the loader itself
//   master : the environment around it (operand source, engine, result consumer)
interface dp_operand_loader_if #(
    parameter int PIXEL_N     = 10,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26
);
    logic                            in_valid;
    logic                            in_ready;
    logic [PIXEL_SIZE-1:0]           in_pixel;
    logic [WEIGHT_SIZE-1:0]          in_weight;
    logic                            in_last;
    logic [PIXEL_N*PIXEL_SIZE-1:0]   dp_pixels;
    logic [PIXEL_N*WEIGHT_SIZE-1:0]  dp_weights;
    logic                            dp_rst;
    logic [VAL_SIZE-1:0]             dp_value;
    logic                            res_valid;
    logic                            res_ready;
    logic [VAL_SIZE-1:0]             res_data;

    modport slave (
        input  in_valid, in_pixel, in_weight, in_last, dp_value, res_ready,
        output in_ready, dp_pixels, dp_weights, dp_rst, res_valid, res_data
    );

    modport master (
        output in_valid, in_pixel, in_weight, in_last, dp_value, res_ready,
        input  in_ready, dp_pixels, dp_weights, dp_rst, res_valid, res_data
    );
endinterface

// File: rtl/dp_operand_loader.sv
// rtl/dp_operand_loader.sv - packs operand pairs for the dot-product engine and captures its result
//
// Ports:
//   clk         : single clock, rising edge
//   GlobalReset : synchronous active-low reset
//   bus         : dp_operand_loader_if.slave (operand stream, engine buses, result stream)
// Flow: LOAD collects pairs into slots (engine held in reset), RUN releases the
// engine for DP_LATENCY cycles, OUT presents the captured value until taken.
module dp_operand_loader #(
    parameter int PIXEL_N     = 10,
    parameter int PIXEL_SIZE  = 10,
    parameter int WEIGHT_SIZE = 19,
    parameter int VAL_SIZE    = 26,
    parameter int DP_LATENCY  = 128
) (
    input  logic                   clk,
    input  logic                   GlobalReset,
    dp_operand_loader_if.slave     bus
);
    localparam int IDX_W = (PIXEL_N > 1) ? $clog2(PIXEL_N) : 1;
    localparam int CNT_W = $clog2(DP_LATENCY + 1);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_RUN  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                          state_q;
    logic [IDX_W-1:0]                idx_q;
    logic [CNT_W-1:0]                cnt_q;
    logic [PIXEL_N*PIXEL_SIZE-1:0]   pix_q;
    logic [PIXEL_N*WEIGHT_SIZE-1:0]  wgt_q;
    logic                            dp_rst_q;
    logic                            res_valid_q;
    logic [VAL_SIZE-1:0]             res_data_q;

    // Ready is a pure state decode so the source never sees a combinational
    // path from its own valid back to ready.
    assign bus.in_ready   = (state_q == S_LOAD);
    assign bus.dp_pixels  = pix_q;
    assign bus.dp_weights = wgt_q;
    assign bus.dp_rst     = dp_rst_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;

    always_ff @(posedge clk) begin
        if (!GlobalReset) begin
            state_q     <= S_LOAD;
            idx_q       <= '0;
            cnt_q       <= '0;
            pix_q       <= '0;
            wgt_q       <= '0;
            dp_rst_q    <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        for (int k = 0; k < PIXEL_N; k++) begin
                            if (idx_q == IDX_W'(k)) begin
                                pix_q[k*PIXEL_SIZE +: PIXEL_SIZE]   <= bus.in_pixel;
                                wgt_q[k*WEIGHT_SIZE +: WEIGHT_SIZE] <= bus.in_weight;
                            end
                        end
                        idx_q <= idx_q + 1'b1;
                        // Untouched slots keep the zeros left by reset or the
                        // previous result handshake, so short vectors are zero-filled.
                        if (bus.in_last || (idx_q == IDX_W'(PIXEL_N - 1))) begin
                            state_q  <= S_RUN;
                            dp_rst_q <= 1'b0;
                            cnt_q    <= '0;
                        end
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Edge E0+DP_LATENCY, counting E0 as the final accept.
                    if (cnt_q == CNT_W'(DP_LATENCY - 1)) begin
                        res_data_q  <= bus.dp_value;
                        res_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (bus.res_ready) begin
                        state_q     <= S_LOAD;
                        idx_q       <= '0;
                        pix_q       <= '0;
                        wgt_q       <= '0;
                        dp_rst_q    <= 1'b1;
                        res_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dp_operand_loader.sv
// tb/tb_dp_operand_loader.sv - directed self-checking bench for dp_operand_loader
module tb_dp_operand_loader;
    localparam int PIXEL_N     = 10;
    localparam int PIXEL_SIZE  = 10;
    localparam int WEIGHT_SIZE = 19;
    localparam int VAL_SIZE    = 26;
    localparam int DP_LATENCY  = 128;
    localparam logic [VAL_SIZE-1:0] STAMP = VAL_SIZE'((DP_LATENCY - 1) << 16);

    logic clk = 1'b0;
    logic GlobalReset = 1'b0;

    dp_operand_loader_if #(
        .PIXEL_N(PIXEL_N), .PIXEL_SIZE(PIXEL_SIZE),
        .WEIGHT_SIZE(WEIGHT_SIZE), .VAL_SIZE(VAL_SIZE)
    ) bus ();

    dp_operand_loader #(
        .PIXEL_N(PIXEL_N), .PIXEL_SIZE(PIXEL_SIZE), .WEIGHT_SIZE(WEIGHT_SIZE),
        .VAL_SIZE(VAL_SIZE), .DP_LATENCY(DP_LATENCY)
    ) dut (
        .clk(clk),
        .GlobalReset(GlobalReset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Model engine: dot product plus a run-cycle stamp in bits [25:16], so the
    // captured value also reveals on which edge it was sampled.
    logic [15:0] eng_cnt = '0;
    always @(posedge clk) begin
        if (bus.dp_rst) eng_cnt <= '0;
        else            eng_cnt <= eng_cnt + 16'd1;
    end

    function automatic logic [VAL_SIZE-1:0] model_dot(
        input logic [PIXEL_N*PIXEL_SIZE-1:0]  p,
        input logic [PIXEL_N*WEIGHT_SIZE-1:0] w
    );
        logic [63:0] acc;
        acc = '0;
        for (int k = 0; k < PIXEL_N; k++)
            acc = acc + 64'(p[k*PIXEL_SIZE +: PIXEL_SIZE]) * 64'(w[k*WEIGHT_SIZE +: WEIGHT_SIZE]);
        return acc[VAL_SIZE-1:0];
    endfunction

    assign bus.dp_value = model_dot(bus.dp_pixels, bus.dp_weights)
                        + {eng_cnt[VAL_SIZE-17:0], 16'h0000};

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int pix, input int wgt, input logic last);
        bus.in_valid  = 1'b1;
        bus.in_pixel  = PIXEL_SIZE'(pix);
        bus.in_weight = WEIGHT_SIZE'(wgt);
        bus.in_last   = last;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
    endtask

    // Edges from now until res_valid is seen high; 0 on timeout.
    task automatic wait_result(output int n);
        n = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic take_result();
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
    endtask

    logic [PIXEL_N*PIXEL_SIZE-1:0]  exp_pix_full, exp_pix_short;
    logic [PIXEL_N*WEIGHT_SIZE-1:0] exp_wgt_full, exp_wgt_short;
    logic [VAL_SIZE-1:0]            held;
    logic                           ok;
    int                             n;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pixel  = '0;
        bus.in_weight = '0;
        bus.in_last   = 1'b0;
        bus.res_ready = 1'b0;

        exp_pix_full  = '0;
        exp_wgt_full  = '0;
        for (int k = 0; k < PIXEL_N; k++) begin
            exp_pix_full[k*PIXEL_SIZE +: PIXEL_SIZE]    = PIXEL_SIZE'(k + 1);
            exp_wgt_full[k*WEIGHT_SIZE +: WEIGHT_SIZE]  = WEIGHT_SIZE'(2 * (k + 1));
        end
        exp_pix_short = '0;
        exp_wgt_short = '0;
        exp_pix_short[0*PIXEL_SIZE +: PIXEL_SIZE]   = 10'd5;
        exp_pix_short[1*PIXEL_SIZE +: PIXEL_SIZE]   = 10'd6;
        exp_pix_short[2*PIXEL_SIZE +: PIXEL_SIZE]   = 10'd7;
        exp_wgt_short[0*WEIGHT_SIZE +: WEIGHT_SIZE] = 19'd3;
        exp_wgt_short[1*WEIGHT_SIZE +: WEIGHT_SIZE] = 19'd4;
        exp_wgt_short[2*WEIGHT_SIZE +: WEIGHT_SIZE] = 19'd1;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("rst_dp_rst", 256'(bus.dp_rst), 256'(1));
        chk("rst_res_valid", 256'(bus.res_valid), 256'(0));
        chk("rst_res_data", 256'(bus.res_data), 256'(0));
        chk("rst_dp_pixels", 256'(bus.dp_pixels), 256'(0));
        chk("rst_dp_weights", 256'(bus.dp_weights), 256'(0));
        GlobalReset = 1'b1;
        @(posedge clk); #1;
        chk("load_dp_rst_high", 256'(bus.dp_rst), 256'(1));

        // Full vector, back-to-back
        for (int k = 0; k < PIXEL_N; k++) begin
            if (k == PIXEL_N - 1) chk("full_ready_before_last", 256'(bus.in_ready), 256'(1));
            send(k + 1, 2 * (k + 1), 1'b0);
        end
        chk("full_pixels", 256'(bus.dp_pixels), 256'(exp_pix_full));
        chk("full_weights", 256'(bus.dp_weights), 256'(exp_wgt_full));
        chk("full_dp_rst_low", 256'(bus.dp_rst), 256'(0));
        chk("full_in_ready_low", 256'(bus.in_ready), 256'(0));
        wait_result(n);
        chk("full_latency", 256'(n), 256'(DP_LATENCY));
        chk("full_res_data", 256'(bus.res_data), 256'(VAL_SIZE'(770) + STAMP));

        // Backpressure
        held = bus.res_data;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (bus.res_data !== held || bus.in_ready !== 1'b0 || bus.res_valid !== 1'b1
                || bus.dp_pixels !== exp_pix_full) ok = 1'b0;
        end
        chk("bp_stable", 256'(ok), 256'(1));
        take_result();
        chk("bp_res_valid_drop", 256'(bus.res_valid), 256'(0));
        chk("bp_in_ready_back", 256'(bus.in_ready), 256'(1));
        chk("bp_dp_rst_back", 256'(bus.dp_rst), 256'(1));
        chk("bp_pixels_clear", 256'(bus.dp_pixels), 256'(0));
        chk("bp_weights_clear", 256'(bus.dp_weights), 256'(0));

        // in_last without valid is ignored
        bus.in_last = 1'b1;
        @(posedge clk); #1;
        bus.in_last = 1'b0;
        chk("last_no_valid_ignored", 256'(bus.in_ready), 256'(1));

        // Short vector
        send(5, 3, 1'b0);
        send(6, 4, 1'b0);
        chk("short_still_loading", 256'(bus.in_ready), 256'(1));
        send(7, 1, 1'b1);
        chk("short_in_run", 256'(bus.in_ready), 256'(0));
        chk("short_dp_rst_low", 256'(bus.dp_rst), 256'(0));
        chk("short_pixels", 256'(bus.dp_pixels), 256'(exp_pix_short));
        chk("short_weights", 256'(bus.dp_weights), 256'(exp_wgt_short));
        wait_result(n);
        chk("short_latency", 256'(n), 256'(DP_LATENCY));
        chk("short_res_data", 256'(bus.res_data), 256'(VAL_SIZE'(46) + STAMP));
        take_result();

        // Bubbled input: idle cycles carry a stray in_last that must be ignored
        for (int k = 0; k < PIXEL_N; k++) begin
            send(k + 1, 2 * (k + 1), 1'b0);
            bus.in_last = 1'b1;
            @(posedge clk); #1;
            bus.in_last = 1'b0;
            if (k == PIXEL_N - 2) chk("bub_still_loading", 256'(bus.in_ready), 256'(1));
        end
        chk("bub_pixels", 256'(bus.dp_pixels), 256'(exp_pix_full));
        chk("bub_weights", 256'(bus.dp_weights), 256'(exp_wgt_full));
        wait_result(n);
        chk("bub_latency", 256'(n), 256'(DP_LATENCY - 1));
        chk("bub_res_data", 256'(bus.res_data), 256'(VAL_SIZE'(770) + STAMP));
        take_result();

        // Mid-run reset at cnt=50
        for (int k = 0; k < PIXEL_N; k++) send(k + 1, 2 * (k + 1), 1'b0);
        repeat (50) @(posedge clk);
        #1;
        GlobalReset = 1'b0;
        @(posedge clk); #1;
        GlobalReset = 1'b1;
        chk("mrst_in_ready", 256'(bus.in_ready), 256'(1));
        chk("mrst_dp_rst", 256'(bus.dp_rst), 256'(1));
        chk("mrst_pixels", 256'(bus.dp_pixels), 256'(0));
        chk("mrst_weights", 256'(bus.dp_weights), 256'(0));
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) ok = 1'b0;
        end
        chk("mrst_no_result", 256'(ok), 256'(1));

        // Single-element vector after the reset
        send(100, 1000, 1'b1);
        chk("single_in_run", 256'(bus.in_ready), 256'(0));
        wait_result(n);
        chk("single_latency", 256'(n), 256'(DP_LATENCY));
        chk("single_res_data", 256'(bus.res_data), 256'(VAL_SIZE'(100000) + STAMP));
        take_result();
        chk("single_back_to_load", 256'(bus.in_ready), 256'(1));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
